// File: rtl/tiles_pkg.sv
// Shared types and constants for the falling-tile lane sequencer.
package tiles_pkg;

   typedef logic [1:0] lane_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HOLD
   } seq_state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int unsigned NUM_LANES = 4;

   // One right-shifting Galois step; taps fold back in when bit 0 shifts out.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances one step per cycle while step_i is high.
module lfsr16
   import tiles_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        step_i,
   output logic [15:0] lfsr_o
);

   // An all-zero register would lock up, so a zero seed is replaced.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= SEED_EFF;
      end else if (step_i) begin
         lfsr_q <= lfsr_step(lfsr_q);
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/tile_sequencer.sv
// Issues one-hot tile lanes row by row, advancing on frame-count expiry or hit,
// with the row period shrinking as the level climbs.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | game not running; no tile shown, counters and LFSR frozen
//   ST_LOAD | single cycle: step LFSR, pick lane, strobe st_chng, count row
//   ST_HOLD | tile shown; count frame ticks until period expiry or hit
module tile_sequencer
   import tiles_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter int unsigned BASE_FRAMES    = 90,
   parameter int unsigned STEP_FRAMES    = 10,
   parameter int unsigned MIN_FRAMES     = 30,
   parameter int unsigned ROWS_PER_LEVEL = 8
) (
   input  logic       clk_d,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       run,
   input  logic       hit,
   output logic [3:0] state,
   output logic       st_chng,
   output logic [2:0] level,
   output logic [9:0] row_count
);

   localparam logic [7:0] BASE8 = 8'(BASE_FRAMES);
   localparam logic [7:0] STEP8 = 8'(STEP_FRAMES);
   localparam logic [7:0] MIN8  = 8'(MIN_FRAMES);

   logic [1:0]  rst_sync_q;
   logic        rst_int_n;

   seq_state_e  fsm_q;
   logic [3:0]  state_q;
   logic        st_chng_q;
   logic [2:0]  level_q;
   logic [9:0]  row_count_q;
   logic [7:0]  frame_cnt_q;
   lane_t       prev_lane_q;

   logic        lfsr_adv;
   logic [15:0] lfsr_cur;
   logic [15:0] lfsr_d;
   lane_t       lane_cand;
   lane_t       lane_d;
   logic [9:0]  row_count_d;
   logic        level_up_d;
   logic [7:0]  frame_cnt_d;
   logic [10:0] period_dec;
   logic [7:0]  period_diff;
   logic [7:0]  period;
   logic        unused_lfsr_hi;

   // Assertion is immediate; release reaches the core two edges later.
   always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   assign lfsr_adv = run && (fsm_q == ST_LOAD);

   lfsr16 #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clk_i  (clk_d),
      .rst_ni (rst_int_n),
      .step_i (lfsr_adv),
      .lfsr_o (lfsr_cur)
   );

   always_comb begin
      lfsr_d      = lfsr_step(lfsr_cur);
      lane_cand   = lfsr_d[1:0];
      lane_d      = (lane_cand == prev_lane_q) ? lane_cand + 2'd1 : lane_cand;
      row_count_d = row_count_q + 10'd1;
      level_up_d  = (32'(row_count_d) % ROWS_PER_LEVEL) == 32'd0;
      frame_cnt_d = frame_cnt_q + 8'd1;
      period_dec  = 11'(level_q) * 11'(STEP8);
      period_diff = BASE8 - period_dec[7:0];
      if ((period_dec > 11'(BASE8)) || (period_diff < MIN8)) begin
         period = MIN8;
      end else begin
         period = period_diff;
      end
   end

   // Only the low two bits of the stepped value choose the lane.
   assign unused_lfsr_hi = ^lfsr_d[15:2];

   always_ff @(posedge clk_d or negedge rst_int_n) begin
      if (!rst_int_n) begin
         fsm_q       <= ST_IDLE;
         state_q     <= 4'b0000;
         st_chng_q   <= 1'b0;
         level_q     <= 3'd0;
         row_count_q <= 10'd0;
         frame_cnt_q <= 8'd0;
         prev_lane_q <= 2'd3;
      end else begin
         st_chng_q <= 1'b0;
         if (!run) begin
            fsm_q   <= ST_IDLE;
            state_q <= 4'b0000;
         end else begin
            case (fsm_q)
               ST_IDLE: begin
                  fsm_q       <= ST_LOAD;
                  level_q     <= 3'd0;
                  row_count_q <= 10'd0;
                  frame_cnt_q <= 8'd0;
               end
               ST_LOAD: begin
                  state_q     <= 4'b0001 << lane_d;
                  st_chng_q   <= 1'b1;
                  prev_lane_q <= lane_d;
                  frame_cnt_q <= 8'd0;
                  row_count_q <= row_count_d;
                  if (level_up_d && (level_q != 3'd7)) begin
                     level_q <= level_q + 3'd1;
                  end
                  fsm_q <= ST_HOLD;
               end
               ST_HOLD: begin
                  if (frame_tick) begin
                     frame_cnt_q <= frame_cnt_d;
                  end
                  if (hit || (frame_tick && (frame_cnt_d >= period))) begin
                     fsm_q <= ST_LOAD;
                  end
               end
               default: fsm_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign state     = state_q;
   assign st_chng   = st_chng_q;
   assign level     = level_q;
   assign row_count = row_count_q;

endmodule
